// File: rtl/vga_state_writer.sv
// vga_state_writer: captures a 7-word game-state snapshot and writes it to the VGA state region.
// Latency: start at edge E -> slot 1 presented from E, slots accepted E+1..E+7 with grant held, done at E+7..E+8.
// Backpressure: mem_gnt low holds the current write (one stall cycle each); one-deep shadow absorbs mid-frame starts.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 sample the snapshot words (mx_in..cont_in) on this edge
//   mem_gnt               memory accepts the presented write on this edge
//   mem_we/addr/data      registered write request to memory
//   busy, done, pending   status: frame in progress, frame-complete pulse, shadow snapshot waiting
//   frames_written        count of completed frames (wraps)
module vga_state_writer #(
   parameter int          ADDR_W    = 16,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned X_OFFSET  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       mx_in,
   input  logic [15:0]       my_in,
   input  logic [15:0]       p1x_in,
   input  logic [15:0]       p1y_in,
   input  logic [15:0]       p2x_in,
   input  logic [15:0]       p2y_in,
   input  logic [15:0]       cont_in,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic              busy,
   output logic              done,
   output logic              pending,
   output logic [15:0]       frames_written
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam logic [15:0]       XOFF   = 16'(X_OFFSET);
   localparam logic [2:0]        LAST   = 3'd7;

   typedef struct packed {
      logic [15:0] mx;
      logic [15:0] my;
      logic [15:0] p1x;
      logic [15:0] p1y;
      logic [15:0] p2x;
      logic [15:0] p2y;
      logic [15:0] cont;
   } snap_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   snap_t       work_q, work_d;
   snap_t       shadow_q, shadow_d;
   logic        pend_q, pend_d;
   logic        we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic [15:0] frames_q, frames_d;

   snap_t snap_in;
   assign snap_in = '{mx: mx_in, my: my_in, p1x: p1x_in, p1y: p1y_in,
                      p2x: p2x_in, p2y: p2y_in, cont: cont_in};

   // Slot order matches the display-side read order; x words carry the offset.
   function automatic logic [15:0] slot_word(input snap_t s, input logic [2:0] i);
      logic [15:0] w;
      unique case (i)
         3'd1:    w = s.mx + XOFF;
         3'd2:    w = s.my;
         3'd3:    w = s.p1x + XOFF;
         3'd4:    w = s.p1y;
         3'd5:    w = s.p2x + XOFF;
         3'd6:    w = s.p2y;
         3'd7:    w = s.cont;
         default: w = 16'd0;
      endcase
      return w;
   endfunction

   function automatic logic [ADDR_W-1:0] slot_addr(input logic [2:0] i);
      return BASE_A + ADDR_W'(i);
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      work_d   = work_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      we_d     = we_q;
      addr_d   = addr_q;
      data_d   = data_q;
      frames_d = frames_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // A fresh start beats the shadow; either way the shadow is consumed.
            if (start || pend_q) begin
               work_d  = start ? snap_in : shadow_q;
               pend_d  = 1'b0;
               state_d = ST_WRITE;
               idx_d   = 3'd1;
               we_d    = 1'b1;
               addr_d  = slot_addr(3'd1);
               // Work registers load this same edge, so slot 1 comes from the source directly.
               data_d  = slot_word(start ? snap_in : shadow_q, 3'd1);
            end else begin
               state_d = ST_IDLE;
               we_d    = 1'b0;
            end
         end
         ST_WRITE: begin
            // Mid-frame starts only ever touch the shadow; latest one wins.
            if (start) begin
               shadow_d = snap_in;
               pend_d   = 1'b1;
            end
            if (mem_gnt) begin
               if (idx_q == LAST) begin
                  we_d     = 1'b0;
                  state_d  = ST_DONE;
                  frames_d = frames_q + 16'd1;
               end else begin
                  idx_d  = idx_q + 3'd1;
                  addr_d = slot_addr(idx_q + 3'd1);
                  data_d = slot_word(work_q, idx_q + 3'd1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= 3'd0;
         work_q   <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= 16'd0;
         frames_q <= 16'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         work_q   <= work_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         frames_q <= frames_d;
      end
   end

   assign mem_we         = we_q;
   assign mem_addr       = addr_q;
   assign mem_data       = data_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = (state_q == ST_DONE);
   assign pending        = pend_q;
   assign frames_written = frames_q;

endmodule

// File: tb/tb_vga_state_writer.sv
module tb_vga_state_writer;

   logic clk = 1'b0;
   logic reset, start, mem_gnt;
   logic [15:0] mx_in, my_in, p1x_in, p1y_in, p2x_in, p2y_in, cont_in;

   logic        we1, busy1, done1, pend1;
   logic [15:0] addr1, data1, fr1;
   logic        we2, busy2, done2, pend2;
   logic [15:0] addr2, data2, fr2;

   always #5 clk = ~clk;

   vga_state_writer dut (
      .clk(clk), .reset(reset), .start(start),
      .mx_in(mx_in), .my_in(my_in), .p1x_in(p1x_in), .p1y_in(p1y_in),
      .p2x_in(p2x_in), .p2y_in(p2y_in), .cont_in(cont_in),
      .mem_gnt(mem_gnt), .mem_we(we1), .mem_addr(addr1), .mem_data(data1),
      .busy(busy1), .done(done1), .pending(pend1), .frames_written(fr1)
   );

   vga_state_writer #(.ADDR_W(16), .BASE_ADDR(32'h1F0), .X_OFFSET(0)) dut2 (
      .clk(clk), .reset(reset), .start(start),
      .mx_in(mx_in), .my_in(my_in), .p1x_in(p1x_in), .p1y_in(p1y_in),
      .p2x_in(p2x_in), .p2y_in(p2y_in), .cont_in(cont_in),
      .mem_gnt(mem_gnt), .mem_we(we2), .mem_addr(addr2), .mem_data(data2),
      .busy(busy2), .done(done2), .pending(pend2), .frames_written(fr2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: position in the frame (0 idle, 1..7 slot on the bus, 8 done cycle),
   // the snapshot being written, the optional waiting snapshot and the frame count.
   int          m_slot;
   logic [15:0] m_cur [7];
   logic [15:0] m_pend [7];
   bit          m_pv;
   logic [15:0] m_frames;

   logic [15:0] zs [7] = '{default: 16'd0};
   logic [15:0] log_a [$];
   logic [15:0] log_d [$];

   function automatic logic [15:0] exp_word(input int k, input logic [15:0] xo);
      logic [15:0] v;
      v = m_cur[k-1];
      if (k == 1 || k == 3 || k == 5) v = v + xo;
      return v;
   endfunction

   task automatic model_reset();
      m_slot = 0; m_pv = 0; m_frames = 16'd0;
      for (int i = 0; i < 7; i++) begin m_cur[i] = 16'd0; m_pend[i] = 16'd0; end
   endtask

   task automatic compare_all();
      check("we", {31'd0, we1}, (m_slot >= 1 && m_slot <= 7));
      check("busy", {31'd0, busy1}, (m_slot != 0));
      check("done", {31'd0, done1}, (m_slot == 8));
      check("pending", {31'd0, pend1}, m_pv);
      check("frames", {16'd0, fr1}, {16'd0, m_frames});
      check("we2", {31'd0, we2}, (m_slot >= 1 && m_slot <= 7));
      check("frames2", {16'd0, fr2}, {16'd0, m_frames});
      if (m_slot >= 1 && m_slot <= 7) begin
         check("addr", {16'd0, addr1}, 32'(m_slot));
         check("data", {16'd0, data1}, {16'd0, exp_word(m_slot, 16'd32)});
         check("addr2", {16'd0, addr2}, 32'h1F0 + 32'(m_slot));
         check("data2", {16'd0, data2}, {16'd0, exp_word(m_slot, 16'd0)});
      end
   endtask

   task automatic check_reset_vals();
      check("rst_we", {31'd0, we1}, 0);
      check("rst_addr", {16'd0, addr1}, 0);
      check("rst_data", {16'd0, data1}, 0);
      check("rst_busy", {31'd0, busy1}, 0);
      check("rst_done", {31'd0, done1}, 0);
      check("rst_pend", {31'd0, pend1}, 0);
      check("rst_frames", {16'd0, fr1}, 0);
      check("rst_we2", {31'd0, we2}, 0);
      check("rst_addr2", {16'd0, addr2}, 0);
   endtask

   // One clock: drive at the falling edge, advance the model, compare after the rising edge.
   task automatic step(input bit st, input bit g, input logic [15:0] s [7]);
      @(negedge clk);
      start = st; mem_gnt = g;
      mx_in = s[0]; my_in = s[1]; p1x_in = s[2]; p1y_in = s[3];
      p2x_in = s[4]; p2y_in = s[5]; cont_in = s[6];
      if (we1 && g) begin log_a.push_back(addr1); log_d.push_back(data1); end
      if (m_slot == 0 || m_slot == 8) begin
         if (st) begin
            m_cur = s; m_slot = 1; m_pv = 0;
         end else if (m_pv) begin
            m_cur = m_pend; m_slot = 1; m_pv = 0;
         end else begin
            m_slot = 0;
         end
      end else begin
         if (st) begin m_pend = s; m_pv = 1; end
         if (g) begin
            if (m_slot == 7) begin m_slot = 8; m_frames = m_frames + 16'd1; end
            else m_slot = m_slot + 1;
         end
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drain();
      int n = 0;
      while ((m_slot != 0 || m_pv) && n < 60) begin
         step(0, 1, zs);
         n++;
      end
      check("drain_bound", {31'd0, (n < 60)}, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_vals();
      @(negedge clk);
      reset = 1'b0;
      log_a.delete(); log_d.delete();
   endtask

   logic [15:0] s1 [7] = '{16'd100, 16'd50, 16'd0, 16'd7, 16'd65520, 16'd9, 16'd3};
   logic [15:0] t1d [7] = '{16'd132, 16'd50, 16'd32, 16'd7, 16'd16, 16'd9, 16'd3};

   function automatic void rand_snap(output logic [15:0] s [7], input logic [15:0] tagv);
      for (int i = 0; i < 7; i++) s[i] = 16'($urandom);
      s[0] = 16'hFFF0 + 16'($urandom_range(0, 31));
      s[6] = tagv;
   endfunction

   initial begin
      logic [15:0] sa [7];
      logic [15:0] sb [7];
      logic [15:0] sc [7];
      int n, bcnt;

      reset = 1'b1; start = 1'b0; mem_gnt = 1'b0;
      mx_in = 0; my_in = 0; p1x_in = 0; p1y_in = 0; p2x_in = 0; p2y_in = 0; cont_in = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      @(negedge clk);
      reset = 1'b0;

      // Single frame, grant always high.
      step(1, 1, s1);
      n = 0;
      while (!done1 && n < 20) begin step(0, 1, zs); n++; end
      check("done_latency", n, 7);
      drain();
      check("t1_frames", {16'd0, fr1}, 1);
      check("t1_nwrites", log_a.size(), 7);
      for (int i = 0; i < 7 && i < log_a.size(); i++) begin
         check("t1_addr", {16'd0, log_a[i]}, 32'(i + 1));
         check("t1_data", {16'd0, log_d[i]}, {16'd0, t1d[i]});
      end

      // Grant low for three cycles while slot 4 is on the bus.
      do_reset();
      step(1, 1, s1);
      n = 0;
      while (!done1 && n < 20) begin
         n++;
         step(0, !(n >= 4 && n <= 6), zs);
      end
      check("stall_latency", n, 10);
      drain();

      // Mid-frame starts B then C: C replaces B and follows A without an idle cycle.
      do_reset();
      rand_snap(sa, 16'hA); rand_snap(sb, 16'hB); rand_snap(sc, 16'hC);
      step(1, 1, sa);
      for (int i = 1; i <= 7; i++) step(i == 2 || i == 4, 1, (i == 2) ? sb : sc);
      check("ovr_pending", {31'd0, pend1}, 1);
      drain();
      check("ovr_frames", {16'd0, fr1}, 2);
      bcnt = 0;
      foreach (log_a[i]) if (log_a[i] == 16'd7 && log_d[i] == 16'hB) bcnt++;
      check("ovr_b_never", bcnt, 0);
      check("ovr_nwrites", log_a.size(), 14);

      // Start arriving in the done cycle while a shadow is pending.
      do_reset();
      rand_snap(sa, 16'h1A); rand_snap(sb, 16'h1B); rand_snap(sc, 16'h1D);
      step(1, 1, sa);
      for (int i = 1; i <= 7; i++) step(i == 3, 1, sb);
      check("done_state", {31'd0, done1}, 1);
      step(1, 1, sc);
      check("done_pend_clr", {31'd0, pend1}, 0);
      drain();
      check("done_frames", {16'd0, fr1}, 2);
      check("done_last_cont", (log_d.size() > 0) ? {16'd0, log_d[log_d.size()-1]} : 32'hFFFF, 32'h1D);

      // Asynchronous reset while slot 3 is on the bus.
      do_reset();
      step(1, 1, s1);
      step(0, 1, zs);
      step(0, 1, zs);
      @(negedge clk);
      check("pre_rst_addr", {16'd0, addr1}, 3);
      check("pre_rst_we", {31'd0, we1}, 1);
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_vals();
      @(negedge clk);
      reset = 1'b0;
      log_a.delete(); log_d.delete();
      step(1, 1, s1);
      drain();
      check("post_rst_first", (log_a.size() > 0) ? {16'd0, log_a[0]} : 32'hFFFF, 1);

      // Randomized traffic.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic [15:0] sr [7];
         rand_snap(sr, 16'($urandom));
         step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, sr);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_state_writer.md
# vga_state_writer

Write-side counterpart of the VGA frame-state reader. Captures a 7-word game-state snapshot (monkey x/y, player 1 x/y, player 2 x/y, control word) from the game/ALU side on a start pulse. Writes the words into the shared VGA state region of memory, slots BASE_ADDR+1 through BASE_ADDR+7, in the order the display side reads them. X coordinates are stored with +X_OFFSET applied; the display side subtracts X_OFFSET on read. Writes use a request/grant handshake. A one-deep pending buffer holds a snapshot that arrives mid-frame.

## Interface
- ADDR_W, 16, memory address width
- BASE_ADDR, 0, slot-0 address of the VGA state region; slot 0 is never written
- X_OFFSET, 32, added (mod 2^16) to mx, p1x, p2x before writing

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  sample snapshot inputs this edge
- mx_in, my_in, p1x_in, p1y_in, p2x_in, p2y_in, cont_in  in  16 each  snapshot words
- mem_gnt  in  1  memory accepts the current write this edge
- mem_we  out  1  write request, registered
- mem_addr  out  ADDR_W  write address, registered
- mem_data  out  16  write data, registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after slot 7 accepted
- pending  out  1  shadow snapshot waiting
- frames_written  out  16  completed frames, wraps at 2^16

## Operation
- Three states:
  - IDLE
  - WRITE: slot index idx 1..7
  - DONE: one cycle
- Slot order:
  - 1 = mx+X_OFFSET
  - 2 = my
  - 3 = p1x+X_OFFSET
  - 4 = p1y
  - 5 = p2x+X_OFFSET
  - 6 = p2y
  - 7 = cont
- Arithmetic: all 16-bit truncating. mem_addr = BASE_ADDR+idx, mod 2^ADDR_W.
- IDLE + start: copy inputs into the work registers; go to WRITE with idx=1, mem_we=1, and slot-1 address/data.
- IDLE + pending (no start): load the shadow into the work registers; clear pending; go to WRITE with idx=1.
- IDLE + start + pending: the start inputs win; pending clears.
- WRITE, mem_gnt=0: hold mem_we, mem_addr and mem_data unchanged.
- WRITE, mem_gnt=1:
  - idx<7: idx+1; present the next slot on the following cycle with mem_we still 1 (back-to-back).
  - idx=7: mem_we=0; go to DONE; frames_written+1.
- DONE: done=1, mem_we=0. At the next edge:
  - start: load the start inputs directly into the work registers; go to WRITE with idx=1; clear pending.
  - else pending: load the shadow; go to WRITE; clear pending.
  - else: go to IDLE.
- start in WRITE: copy inputs into the shadow and set pending. A later start overwrites the shadow (latest wins). The in-flight frame is never altered.
- Work registers are stable for a whole frame; the input words need to be valid only on the start edge.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, pending=0, frames_written=0. State=IDLE, idx=0, work and shadow registers=0.
- Reset asserted mid-frame: mem_we drops asynchronously and the pending snapshot is discarded. Slots already written stay in memory; no partial-frame recovery.
- Latency with start at edge E and mem_gnt tied 1:
  - mem_we high from E to E+7; slots 1..7 accepted at edges E+1..E+7.
  - done high from E+7 to E+8; busy high from E to E+8.
  - Next frame's earliest start edge: E+8 (DONE) or later.
- Each cycle mem_gnt is low inserts exactly one stall cycle. Frame duration = 8 + stall cycles.
- mem_gnt while mem_we=0 is ignored.

## Test plan
- Single frame, gnt=1:
  - Stimulus: start with mx=100, my=50, p1x=0, p1y=7, p2x=65520, p2y=9, cont=3.
  - Required: writes at addr 1..7 of data 132, 50, 32, 7, 65520+32=16 (wrapped), 9, 3.
  - Required: done pulse 7 cycles after start; frames_written=1.
- Stalls:
  - Stimulus: mem_gnt low for 3 cycles on slot 4.
  - Required: addr=4 and data held stable for 4 cycles; slot 5 follows; done arrives 3 cycles late.
- Pending overwrite:
  - Stimulus: start frame A, then starts B and C during WRITE.
  - Required: pending=1; A completes untouched; C is written immediately after DONE (no IDLE cycle); B is never written; frames_written=2.
- Start in DONE with pending set:
  - Stimulus: start D arrives while in DONE and a snapshot is pending.
  - Required: D is written; the shadow snapshot is dropped; pending=0.
- Async reset at slot 3:
  - Stimulus: assert reset while slot 3 is being written.
  - Required: mem_we=0 without waiting for a clock edge; all outputs at their reset values; a fresh start then writes from slot 1.
- Parameters BASE_ADDR=0x1F0, X_OFFSET=0:
  - Required: addresses 0x1F1..0x1F7; x words written unmodified.
